ex3_to_bcd_deser: RTL

//  Receive-side companion of the team's BCD-to-Excess-3 encoder. Accepts a serial

---
 rtl/ex3_to_bcd_deser.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ex3_to_bcd_deser.sv
// -----------------------------------------------------------------------------
// ex3_to_bcd_deser
//   Receive-side Excess-3 deserializer. Accepts one 4-bit Excess-3 code per
//   valid/ready transfer (most significant digit first), decodes it to BCD
//   and packs NDIGITS digits into one word offered on a valid/ready output.
//   Illegal codes (0,1,2,D,E,F) are stored as 4'h0 and flagged per digit.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   clr        in   1            synchronous abort, drops partial and held word
//   in_valid   in   1            in_code carries a digit this cycle
//   in_ready   out  1            block accepts a digit this cycle
//   in_code    in   4            Excess-3 digit, legal range 4'h3..4'hC
//   out_valid  out  1            out_bcd/out_err/out_bad hold a complete word
//   out_ready  in   1            consumer takes the word this cycle
//   out_bcd    out  4*NDIGITS    packed BCD, first digit in the MS nibble
//   out_err    out  1            OR of out_bad
//   out_bad    out  NDIGITS      per-digit illegal flag, MSB = first digit
//   digit_cnt  out  CW           digits collected in the current word
// -----------------------------------------------------------------------------
module ex3_to_bcd_deser #(
  parameter  int NDIGITS = 4,
  localparam int CW      = $clog2(NDIGITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic                   out_err,
  output logic [NDIGITS-1:0]     out_bad,
  output logic [CW-1:0]          digit_cnt
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]           state;
  logic                 accept;
  logic                 last_digit;
  logic                 code_bad;
  logic [3:0]           code_bcd;
  logic [4*NDIGITS-1:0] bcd_shift;
  logic [NDIGITS-1:0]   bad_shift;

  // Handshake: a held word blocks input unless it retires this same cycle,
  // and clr refuses any offered digit.
  assign in_ready   = !clr && ((state == COLLECT) || out_ready);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign last_digit = (digit_cnt == CW'(NDIGITS - 1));

  // Per-digit decode. Illegal codes collapse to zero so in_code never leaks
  // into the packed word.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    code_bad = 1'b1;
    code_bcd = 4'h0;
    if (in_code >= 4'h3 && in_code <= 4'hC) begin
      code_bad = 1'b0;
      code_bcd = in_code - 4'd3;
    end
  end

  // New digit enters at the LS end; earlier digits move toward the MS end.
  assign bcd_shift = {out_bcd[4*NDIGITS-5:0], code_bcd};
  assign bad_shift = {out_bad[NDIGITS-2:0], code_bad};

  // NOTE: the reset branch is sensitive to negedge rst_n, so reset takes effect without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state     <= COLLECT;
      out_bcd   <= '0;
      out_bad   <= '0;
      out_err   <= 1'b0;
      digit_cnt <= '0;
    end else if (clr) begin
      state     <= COLLECT;
      out_bcd   <= '0;
      out_bad   <= '0;
      out_err   <= 1'b0;
      digit_cnt <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            out_bcd <= bcd_shift;
            out_bad <= bad_shift;
            out_err <= |bad_shift;
            if (last_digit) begin
              state     <= HOLD;
              digit_cnt <= '0;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= COLLECT;
            if (in_valid) begin
              // Word retires and the incoming digit starts the next one.
              out_bcd   <= {{(4*NDIGITS-4){1'b0}}, code_bcd};
              out_bad   <= {{(NDIGITS-1){1'b0}}, code_bad};
              out_err   <= code_bad;
              digit_cnt <= CW'(1);
            end else begin
              out_bcd   <= '0;
              out_bad   <= '0;
              out_err   <= 1'b0;
              digit_cnt <= '0;
            end
          end
        end
        default: begin
          state     <= COLLECT;
          digit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
